// File: rtl/cobs_cmd_pkg.sv
// Shared constants and parse-state encoding for the COBS command receiver.
package cobs_cmd_pkg;

    localparam logic [7:0] COBS_DELIM = 8'h00;
    localparam logic [7:0] OP_WR_INC  = 8'h01;
    localparam logic [7:0] OP_WR_FIX  = 8'h02;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_ADDR    = 2'd1,
        ST_DATA    = 2'd2,
        ST_DISCARD = 2'd3
    } parse_state_t;

    function automatic logic is_write_op(input logic [7:0] op);
        return (op == OP_WR_INC) || (op == OP_WR_FIX);
    endfunction

endpackage

// File: rtl/cobs_unstuff.sv
// Registered COBS decoder: one decoded event (byte or delimiter) per accepted input byte.
module cobs_unstuff
    import cobs_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_last,
    output logic       o_err,
    input  logic       i_ready
);

    logic [7:0] r_cnt;
    logic       r_in_frame;
    logic       r_ovh;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_last;
    logic       r_err;

    logic       w_acc;
    logic [7:0] w_cnt;
    logic       w_in_frame;
    logic       w_ovh;
    logic       w_emit;
    logic [7:0] w_byte;
    logic       w_dlm;
    logic       w_ovr;

    // The stage advances only when the consumer advances, so a stall freezes it.
    assign o_ready = i_ready;
    assign w_acc   = i_valid && i_ready;

    // Block decode: code bytes load the literal count, the implied zero rides on the next code byte.
    always_comb begin
        w_cnt      = r_cnt;
        w_in_frame = r_in_frame;
        w_ovh      = r_ovh;
        w_emit     = 1'b0;
        w_byte     = i_data;
        w_dlm      = 1'b0;
        w_ovr      = 1'b0;
        if (w_acc) begin
            if (i_data == COBS_DELIM) begin
                w_dlm      = r_in_frame;
                w_ovr      = r_in_frame && (r_cnt != 8'd0);
                w_in_frame = 1'b0;
                w_cnt      = 8'd0;
                w_ovh      = 1'b0;
            end else if (r_cnt == 8'd0) begin
                w_emit     = r_in_frame && !r_ovh;
                w_byte     = 8'h00;
                w_in_frame = 1'b1;
                w_cnt      = i_data - 8'd1;
                w_ovh      = (i_data == 8'hFF);
            end else begin
                w_emit = 1'b1;
                w_cnt  = r_cnt - 8'd1;
            end
        end else begin
            w_emit = 1'b0;
        end
    end

    // Decoder state and output event register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 8'd0;
            r_in_frame <= 1'b0;
            r_ovh      <= 1'b0;
            r_data     <= 8'd0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
        end else if (i_ready) begin
            r_cnt      <= w_cnt;
            r_in_frame <= w_in_frame;
            r_ovh      <= w_ovh;
            r_data     <= w_emit ? w_byte : r_data;
            r_valid    <= w_emit || w_dlm;
            r_last     <= w_dlm;
            r_err      <= w_ovr;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_err   = r_err;

endmodule

// File: rtl/cobs_cmd_burst.sv
// COBS command receiver: parses opcode/address/data words into write beats with one-word hold-back.
module cobs_cmd_burst
    import cobs_cmd_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 24,
    parameter int MAX_BURST = 16,
    parameter int ECW       = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     i_data,
    input  logic           i_valid,
    output logic           o_ready,
    output logic [AW-1:0]  o_addr,
    output logic [DW-1:0]  o_data,
    output logic           o_valid,
    input  logic           i_ready,
    output logic           o_last,
    output logic           o_err,
    output logic [ECW-1:0] err_count
);

    localparam int AB  = AW / 8;
    localparam int DB  = DW / 8;
    localparam int WCW = $clog2(MAX_BURST + 2);

    logic           w_adv, w_ev;
    logic [7:0]     w_u_data;
    logic           w_u_valid, w_u_last, w_u_err, w_u_ready;

    parse_state_t   r_state, w_state;
    logic [3:0]     r_bcnt, w_bcnt;
    logic [WCW-1:0] r_wcnt, w_wcnt;
    logic           r_inc, w_inc;
    logic [AW-1:0]  r_addr, w_addr, w_addr_sh;
    logic [DW-1:0]  r_word, w_word, w_word_sh;
    logic           r_pend_v, w_pend_v;
    logic [AW-1:0]  r_pend_addr, w_pend_addr;
    logic [DW-1:0]  r_pend_data, w_pend_data;
    logic           w_push, w_push_last, w_err;

    logic           r_o_valid, r_o_last, r_o_err;
    logic [AW-1:0]  r_o_addr;
    logic [DW-1:0]  r_o_data;
    logic [ECW-1:0] r_err_cnt;

    assign w_adv = !r_o_valid || i_ready;

    cobs_unstuff u_unstuff (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (w_u_ready),
        .o_data  (w_u_data),
        .o_valid (w_u_valid),
        .o_last  (w_u_last),
        .o_err   (w_u_err),
        .i_ready (w_adv)
    );

    assign o_ready   = w_u_ready;
    assign w_ev      = w_u_valid && w_adv;
    assign w_addr_sh = (r_addr << 8) | AW'(w_u_data);
    assign w_word_sh = (r_word << 8) | DW'(w_u_data);

    // Frame parser: next state, pending-word management, beat push and error detection.
    always_comb begin
        w_state     = r_state;
        w_bcnt      = r_bcnt;
        w_wcnt      = r_wcnt;
        w_inc       = r_inc;
        w_addr      = r_addr;
        w_word      = r_word;
        w_pend_v    = r_pend_v;
        w_pend_addr = r_pend_addr;
        w_pend_data = r_pend_data;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_err       = 1'b0;
        if (w_ev && w_u_last) begin
            w_state  = ST_HDR;
            w_bcnt   = 4'd0;
            w_wcnt   = '0;
            w_pend_v = 1'b0;
            case (r_state)
                ST_DISCARD: w_err = 1'b0;
                ST_DATA: begin
                    if (w_u_err || (r_bcnt != 4'd0) || (r_wcnt == '0)) begin
                        w_err = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_push_last = 1'b1;
                    end
                end
                default: w_err = 1'b1;
            endcase
        end else if (w_ev) begin
            case (r_state)
                ST_HDR: begin
                    if (is_write_op(w_u_data)) begin
                        w_state = ST_ADDR;
                        w_inc   = (w_u_data == OP_WR_INC);
                        w_bcnt  = 4'd0;
                    end else begin
                        w_err   = 1'b1;
                        w_state = ST_DISCARD;
                    end
                end
                ST_ADDR: begin
                    w_addr = w_addr_sh;
                    if (r_bcnt == 4'(AB - 1)) begin
                        w_state = ST_DATA;
                        w_bcnt  = 4'd0;
                    end else begin
                        w_bcnt = r_bcnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    w_word = w_word_sh;
                    if (r_bcnt == 4'(DB - 1)) begin
                        w_bcnt = 4'd0;
                        w_wcnt = r_wcnt + WCW'(1);
                        if (r_wcnt == WCW'(MAX_BURST)) begin
                            w_err    = 1'b1;
                            w_state  = ST_DISCARD;
                            w_pend_v = 1'b0;
                        end else begin
                            w_push      = r_pend_v;
                            w_pend_v    = 1'b1;
                            w_pend_addr = r_addr;
                            w_pend_data = w_word_sh;
                            w_addr      = r_inc ? (r_addr + AW'(1)) : r_addr;
                        end
                    end else begin
                        w_bcnt = r_bcnt + 4'd1;
                    end
                end
                default: w_state = ST_DISCARD;
            endcase
        end else begin
            w_err = 1'b0;
        end
    end

    // Parser state, pending word, output beat register and saturating error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_HDR;
            r_bcnt      <= 4'd0;
            r_wcnt      <= '0;
            r_inc       <= 1'b0;
            r_addr      <= '0;
            r_word      <= '0;
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_o_valid   <= 1'b0;
            r_o_addr    <= '0;
            r_o_data    <= '0;
            r_o_last    <= 1'b0;
            r_o_err     <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state;
            r_bcnt      <= w_bcnt;
            r_wcnt      <= w_wcnt;
            r_inc       <= w_inc;
            r_addr      <= w_addr;
            r_word      <= w_word;
            r_pend_v    <= w_pend_v;
            r_pend_addr <= w_pend_addr;
            r_pend_data <= w_pend_data;
            r_o_err     <= w_err;
            if (w_adv) begin
                r_o_valid <= w_push;
                r_o_last  <= w_push_last;
                if (w_push) begin
                    r_o_addr <= r_pend_addr;
                    r_o_data <= r_pend_data;
                end
            end
            if (w_err && (r_err_cnt != {ECW{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ECW'(1);
            end
        end
    end

    assign o_valid   = r_o_valid;
    assign o_addr    = r_o_addr;
    assign o_data    = r_o_data;
    assign o_last    = r_o_last;
    assign o_err     = r_o_err;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_cobs_cmd_burst.sv
// Scoreboard bench for cobs_cmd_burst: directed frames, monitor compares every delivered beat.
module tb_cobs_cmd_burst;

    typedef struct packed {
        logic [7:0]  a;
        logic [23:0] d;
        logic        l;
    } beat_t;
    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  o_addr;
    logic [23:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_last;
    logic        o_err;
    logic [15:0] err_count;

    int    n_vec = 0, n_miss = 0, cyc = 0;
    int    err_pulses = 0, exp_err = 0, last_cyc = 0, err_cyc = 0;
    int    stall_seen = 0, stall_req = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    cobs_cmd_burst #(.AW(8), .DW(24), .MAX_BURST(16), .ECW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_addr    (o_addr),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_last    (o_last),
        .o_err     (o_err),
        .err_count (err_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [7:0] a, input logic [23:0] d, input logic l);
        beat_t b;
        b = '{a: a, d: d, l: l};
        exp_q.push_back(b);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req > 0) begin
                i_ready = 1'b0;
                stall_req--;
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    // Monitor: pop-and-compare on every transfer, count error pulses, watch held payload during stalls.
    initial begin
        beat_t e, held;
        bit    held_v;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held_v = 1'b0;
            end else begin
                if (o_err) begin
                    err_pulses++;
                    err_cyc = cyc;
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_beat: got addr %0h data %0h last %0b, required no beat",
                                 o_addr, o_data, o_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_addr", o_addr, e.a);
                        check("beat_data", o_data, e.d);
                        check("beat_last", o_last, e.l);
                        if (o_last) last_cyc = cyc;
                    end
                    held_v = 1'b0;
                end else if (o_valid && !i_ready) begin
                    stall_seen++;
                    check("stall_o_ready", o_ready, 1'b0);
                    if (held_v) check("stall_payload", {o_addr, o_data, o_last}, held);
                    held   = '{a: o_addr, d: o_data, l: o_last};
                    held_v = 1'b1;
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int acc);
        bit ok;
        ok      = 1'b0;
        acc     = -1;
        i_data  = b;
        i_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (o_ready) begin
                ok  = 1'b1;
                acc = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: byte %0h not accepted within 50 cycles", b);
        end
        i_valid = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t f, output int acc);
        acc = -1;
        foreach (f[i]) send_byte(f[i], acc);
    endtask

    task automatic settle(input string name);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_missing_beats"}, exp_q.size(), 0);
        check({name, "_err_count"}, err_count, exp_err);
        check({name, "_err_pulses"}, err_pulses, exp_err);
        exp_q.delete();
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_last", o_last, 1'b0);
        check("rst_o_addr", o_addr, 8'h00);
        check("rst_o_data", o_data, 24'h000000);
        check("rst_o_err", o_err, 1'b0);
        check("rst_err_count", err_count, 16'h0000);
        check("rst_o_ready", o_ready, 1'b1);
    endtask

    initial begin
        int      d;
        byte_q_t f;
        rst     = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        repeat (2) @(posedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b1;

        exp_beat(8'h10, 24'hAABBCC, 1'b1);
        send_frame('{8'h06, 8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h00}, d);
        settle("single");
        check("last_latency", 64'(last_cyc - d), 64'd2);

        exp_beat(8'hFF, 24'h112233, 1'b0);
        exp_beat(8'h00, 24'h445566, 1'b1);
        send_frame('{8'h09, 8'h01, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00}, d);
        settle("wrap");

        exp_beat(8'h20, 24'h000001, 1'b1);
        send_frame('{8'h03, 8'h02, 8'h20, 8'h01, 8'h02, 8'h01, 8'h00}, d);
        settle("stuff");

        exp_err = 1;
        send_frame('{8'h05, 8'h01, 8'h10, 8'hAA, 8'hBB, 8'h00}, d);
        settle("partial");
        check("err_latency", 64'(err_cyc - d), 64'd2);

        exp_err = 2;
        send_frame('{8'h06, 8'h07, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h00}, d);
        settle("badop");

        exp_err = 3;
        send_frame('{8'h08, 8'h01, 8'h10, 8'hAA, 8'h00}, d);
        settle("trunc");

        send_frame('{8'h00}, d);
        settle("empty");

        exp_err = 4;
        send_frame('{8'h01, 8'h00}, d);
        settle("code_only");

        exp_beat(8'h30, 24'h010203, 1'b0);
        exp_beat(8'h31, 24'h040506, 1'b0);
        exp_beat(8'h32, 24'h070809, 1'b0);
        exp_beat(8'h33, 24'h0A0B0C, 1'b1);
        send_frame('{8'h0F, 8'h01, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, d);
        stall_req = 5;
        send_frame('{8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h00}, d);
        settle("backpressure");
        check("stall_observed", stall_seen > 0, 1'b1);

        f = '{8'h36, 8'h01, 8'h40};
        for (int i = 0; i < 17; i++) begin
            f.push_back(8'(i + 1));
            f.push_back(8'h11);
            f.push_back(8'h22);
            if (i < 15) exp_beat(8'(8'h40 + i), {8'(i + 1), 8'h11, 8'h22}, 1'b0);
        end
        f.push_back(8'h00);
        exp_err = 5;
        send_frame(f, d);
        settle("overflow");

        send_frame('{8'h06, 8'h01, 8'h10, 8'hAA}, d);
        rst        = 1'b0;
        exp_err    = 0;
        err_pulses = 0;
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b1;

        exp_beat(8'h55, 24'h123456, 1'b1);
        send_frame('{8'h06, 8'h02, 8'h55, 8'h12, 8'h34, 8'h56, 8'h00}, d);
        settle("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
